// File: rtl/rd_xfr_sequencer.sv
// rd_xfr_sequencer
//   Sequences one RD data transfer per shower trigger:
//   1. claims a free ping-pong capture buffer;
//   2. pulses RD_TRIGGER for TRIG_WIDTH cycles;
//   3. waits for the RD to raise ENABLE_XFR;
//   4. counts deserializer words until ENABLE_XFR falls;
//   5. closes the transfer with a status code.
//
// Optional feature macro: RD_TIMEOUT_EN
//   defined   -> WAIT_XFR and XFR give up after TIMEOUT cycles (ERR_CODE=1)
//   undefined -> no timeout counter; only ENABLE deassertion leaves those states
//
// Ports
//   CLK, RESET    clock, asynchronous active-high reset
//   ENABLE        software enable
//   EVT_TRIGGER   one-cycle shower trigger
//   ENABLE_XFR    RD transfer-enable (already synchronized)
//   WORD_STROBE   one pulse per received word
//   BUF_RELEASE   per-buffer release pulse from software
//   RD_ENABLE     registered copy of ENABLE
//   RD_TRIGGER    trigger pulse to the RD
//   WR_BUF        buffer being written
//   BUF_FULL      per-buffer full flags
//   WORD_COUNT    words of current/last transfer
//   XFR_DONE      transfer-closed pulse
//   XFR_ERR       XFR_DONE with non-zero status
//   ERR_CODE      0 ok, 1 timeout, 2 short, 3 overrun
//   LOST_TRIG     saturating dropped-trigger count
//   STATE         IDLE=0 TRIG=1 WAIT_XFR=2 XFR=3 DONE=4
module rd_xfr_sequencer #(
  parameter int MEM_SIZE   = 2048,
  parameter int TRIG_WIDTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        EVT_TRIGGER,
  input  logic        ENABLE_XFR,
  input  logic        WORD_STROBE,
  input  logic [1:0]  BUF_RELEASE,
  output logic        RD_ENABLE,
  output logic        RD_TRIGGER,
  output logic        WR_BUF,
  output logic [1:0]  BUF_FULL,
  output logic [11:0] WORD_COUNT,
  output logic        XFR_DONE,
  output logic        XFR_ERR,
  output logic [1:0]  ERR_CODE,
  output logic [7:0]  LOST_TRIG,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TRIG     = 3'd1,
    S_WAIT_XFR = 3'd2,
    S_XFR      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [11:0] MEM_LAST  = 12'(MEM_SIZE);
  localparam logic [3:0]  TRIG_LAST = 4'(TRIG_WIDTH - 1);

  state_t      state_reg, state_next;
  logic        rd_enable_reg;
  logic        enable_xfr_reg;
  logic        rd_trigger_reg, rd_trigger_next;
  logic        wr_buf_reg, wr_buf_next;
  logic [1:0]  buf_full_reg, buf_full_next;
  logic [11:0] word_count_reg, word_count_next;
  logic        overrun_reg, overrun_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic [7:0]  lost_trig_reg, lost_trig_next;
  logic [3:0]  trig_cnt_reg, trig_cnt_next;

  logic xfr_rise, xfr_fall, timeout_hit, trig_accept, trig_drop;

  // Edges are taken against last cycle's ENABLE_XFR.
  assign xfr_rise = ENABLE_XFR & ~enable_xfr_reg;
  assign xfr_fall = ~ENABLE_XFR & enable_xfr_reg;

  assign trig_accept = (state_reg == S_IDLE) && EVT_TRIGGER && ENABLE && !(&buf_full_reg);
  // Any enabled trigger that is not accepted is a lost one.
  assign trig_drop   = EVT_TRIGGER && ENABLE && !trig_accept;

`ifdef RD_TIMEOUT_EN
  logic [15:0] timer_reg;

  // Reloads on every state change, so it restarts on entry to WAIT_XFR and XFR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timer_reg <= '0;
    end else if (state_next != state_reg) begin
      timer_reg <= '0;
    end else if (state_reg == S_WAIT_XFR || state_reg == S_XFR) begin
      timer_reg <= timer_reg + 16'd1;
    end
  end

  assign timeout_hit = (timer_reg == 16'(TIMEOUT - 1));
`else
  // TIMEOUT is at least 1, so this is a constant 0: no timeout path exists.
  assign timeout_hit = (TIMEOUT == 0);
`endif

  always_comb begin
    state_next      = state_reg;
    wr_buf_next     = wr_buf_reg;
    // Release first so that a coincident DONE set below wins.
    buf_full_next   = buf_full_reg & ~BUF_RELEASE;
    word_count_next = word_count_reg;
    overrun_next    = overrun_reg;
    err_code_next   = err_code_reg;
    trig_cnt_next   = trig_cnt_reg;
    lost_trig_next  = lost_trig_reg;

    if (trig_drop && lost_trig_reg != 8'hFF) begin
      lost_trig_next = lost_trig_reg + 8'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (trig_accept) begin
          state_next      = S_TRIG;
          wr_buf_next     = buf_full_reg[0];  // lowest-index free buffer
          word_count_next = '0;
          overrun_next    = 1'b0;
          err_code_next   = 2'd0;
          trig_cnt_next   = '0;
        end
      end
      S_TRIG: begin
        if (!ENABLE) begin
          state_next = S_IDLE;
        end else if (trig_cnt_reg == TRIG_LAST) begin
          state_next = S_WAIT_XFR;
        end else begin
          trig_cnt_next = trig_cnt_reg + 4'd1;
        end
      end
      S_WAIT_XFR: begin
        if (!ENABLE) begin
          state_next = S_IDLE;
        end else if (xfr_rise) begin
          state_next = S_XFR;
        end else if (timeout_hit) begin
          err_code_next = 2'd1;
          state_next    = S_DONE;
        end
      end
      S_XFR: begin
        if (!ENABLE) begin
          state_next = S_IDLE;
        end else begin
          if (WORD_STROBE) begin
            if (word_count_reg == MEM_LAST) begin
              overrun_next = 1'b1;
            end else begin
              word_count_next = word_count_reg + 12'd1;
            end
          end
          // Status uses the post-strobe values so a last-cycle word is included.
          if (xfr_fall) begin
            state_next = S_DONE;
            if (overrun_next) begin
              err_code_next = 2'd3;
            end else if (word_count_next < MEM_LAST) begin
              err_code_next = 2'd2;
            end else begin
              err_code_next = 2'd0;
            end
          end else if (timeout_hit) begin
            err_code_next = 2'd1;
            state_next    = S_DONE;
          end
        end
      end
      S_DONE: begin
        buf_full_next[wr_buf_reg] = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    rd_trigger_next = (state_next == S_TRIG);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= S_IDLE;
      rd_enable_reg  <= 1'b0;
      enable_xfr_reg <= 1'b0;
      rd_trigger_reg <= 1'b0;
      wr_buf_reg     <= 1'b0;
      buf_full_reg   <= '0;
      word_count_reg <= '0;
      overrun_reg    <= 1'b0;
      err_code_reg   <= '0;
      lost_trig_reg  <= '0;
      trig_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      rd_enable_reg  <= ENABLE;
      enable_xfr_reg <= ENABLE_XFR;
      rd_trigger_reg <= rd_trigger_next;
      wr_buf_reg     <= wr_buf_next;
      buf_full_reg   <= buf_full_next;
      word_count_reg <= word_count_next;
      overrun_reg    <= overrun_next;
      err_code_reg   <= err_code_next;
      lost_trig_reg  <= lost_trig_next;
      trig_cnt_reg   <= trig_cnt_next;
    end
  end

  assign RD_ENABLE  = rd_enable_reg;
  assign RD_TRIGGER = rd_trigger_reg;
  assign WR_BUF     = wr_buf_reg;
  assign BUF_FULL   = buf_full_reg;
  assign WORD_COUNT = word_count_reg;
  assign XFR_DONE   = (state_reg == S_DONE);
  assign XFR_ERR    = (state_reg == S_DONE) && (err_code_reg != 2'd0);
  assign ERR_CODE   = err_code_reg;
  assign LOST_TRIG  = lost_trig_reg;
  assign STATE      = state_reg;

endmodule

// File: tb/tb_rd_xfr_sequencer.sv
// Testbench for rd_xfr_sequencer (MEM_SIZE=32, TRIG_WIDTH=4, TIMEOUT=100).
// Stimulus pushes the expected closing status of each transfer into a queue;
// a monitor pops and compares on every XFR_DONE.
module tb_rd_xfr_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        EVT_TRIGGER;
  logic        ENABLE_XFR;
  logic        WORD_STROBE;
  logic [1:0]  BUF_RELEASE;
  logic        RD_ENABLE, RD_TRIGGER, WR_BUF, XFR_DONE, XFR_ERR;
  logic [1:0]  BUF_FULL, ERR_CODE;
  logic [11:0] WORD_COUNT;
  logic [7:0]  LOST_TRIG;
  logic [2:0]  STATE;

  rd_xfr_sequencer #(.MEM_SIZE(32), .TRIG_WIDTH(4), .TIMEOUT(100)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .EVT_TRIGGER(EVT_TRIGGER),
    .ENABLE_XFR(ENABLE_XFR), .WORD_STROBE(WORD_STROBE), .BUF_RELEASE(BUF_RELEASE),
    .RD_ENABLE(RD_ENABLE), .RD_TRIGGER(RD_TRIGGER), .WR_BUF(WR_BUF),
    .BUF_FULL(BUF_FULL), .WORD_COUNT(WORD_COUNT), .XFR_DONE(XFR_DONE),
    .XFR_ERR(XFR_ERR), .ERR_CODE(ERR_CODE), .LOST_TRIG(LOST_TRIG), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  err;
    logic [11:0] wc;
    logic        wbuf;
    logic        xerr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   fails   = 0;
  int   xfr_num = 0;
  int   trig_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: closing status and RD_TRIGGER pulse width.
  always @(negedge CLK) begin
    if (XFR_DONE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfr_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        xfr_num++;
        $display("xfr %0d: buf=%0d words=%0d err=%0d xerr=%0d", xfr_num, WR_BUF, WORD_COUNT, ERR_CODE, XFR_ERR);
        chk("err_code", 32'(ERR_CODE), 32'(e.err));
        chk("word_count", 32'(WORD_COUNT), 32'(e.wc));
        chk("wr_buf", 32'(WR_BUF), 32'(e.wbuf));
        chk("xfr_err", 32'(XFR_ERR), 32'(e.xerr));
      end
    end
    if (RD_TRIGGER) begin
      trig_len++;
    end else if (trig_len != 0) begin
      chk("rd_trigger_width", 32'(trig_len), 32'd4);
      trig_len = 0;
    end
  end

  task automatic pulse_trig();
    EVT_TRIGGER = 1'b1;
    tick(1);
    EVT_TRIGGER = 1'b0;
  endtask

  task automatic release_bufs(input logic [1:0] m);
    BUF_RELEASE = m;
    tick(1);
    BUF_RELEASE = 2'b00;
  endtask

  // Trigger, pass TRIG, raise ENABLE_XFR, then send n words.
  task automatic start_xfr(input int n);
    pulse_trig();
    tick(5);
    ENABLE_XFR = 1'b1;
    tick(1);
    for (int i = 0; i < n; i++) begin
      WORD_STROBE = 1'b1;
      tick(1);
    end
    WORD_STROBE = 1'b0;
  endtask

  task automatic do_xfr(input int n, input logic [1:0] err, input logic [11:0] wc, input logic wb);
    exp_t e;
    e.err = err; e.wc = wc; e.wbuf = wb; e.xerr = (err != 2'd0);
    exp_q.push_back(e);
    start_xfr(n);
    ENABLE_XFR = 1'b0;
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; EVT_TRIGGER = 1'b0; ENABLE_XFR = 1'b0;
    WORD_STROBE = 1'b0; BUF_RELEASE = 2'b00;
    #2;
    chk("reset_outputs", {RD_ENABLE, RD_TRIGGER, WR_BUF, BUF_FULL, WORD_COUNT, XFR_DONE,
                          XFR_ERR, ERR_CODE, LOST_TRIG, STATE}, 32'd0);
    tick(2);
    RESET = 1'b0; ENABLE = 1'b1;
    tick(2);
    chk("rd_enable_follow", 32'(RD_ENABLE), 32'd1);

    // Nominal
    do_xfr(32, 2'd0, 12'd32, 1'b0);
    chk("nominal_buf_full", 32'(BUF_FULL), 32'b01);

    // Ping-pong and loss counting
    do_xfr(32, 2'd0, 12'd32, 1'b1);
    chk("pingpong_buf_full", 32'(BUF_FULL), 32'b11);
    pulse_trig();
    tick(1);
    chk("lost_trig_full", 32'(LOST_TRIG), 32'd1);
    chk("state_idle_full", 32'(STATE), 32'd0);
    release_bufs(2'b01);
    chk("release_buf0", 32'(BUF_FULL), 32'b10);
    do_xfr(32, 2'd0, 12'd32, 1'b0);
    chk("refill_buf_full", 32'(BUF_FULL), 32'b11);
    release_bufs(2'b11);
    chk("release_all", 32'(BUF_FULL), 32'b00);

    // Short and overrun
    do_xfr(20, 2'd2, 12'd20, 1'b0);
    release_bufs(2'b01);
    do_xfr(35, 2'd3, 12'd32, 1'b0);
    release_bufs(2'b01);

    // Timeout
`ifdef RD_TIMEOUT_EN
    begin
      exp_t e;
      int n;
      e.err = 2'd1; e.wc = 12'd0; e.wbuf = 1'b0; e.xerr = 1'b1;
      exp_q.push_back(e);
      pulse_trig();
      n = 0;
      for (int i = 1; i <= 200; i++) begin
        tick(1);
        n = i;
        if (XFR_DONE) break;
      end
      chk("timeout_latency", 32'(n), 32'd104);
      tick(1);
      chk("timeout_buf_full", 32'(BUF_FULL), 32'b01);
      release_bufs(2'b01);
    end
`else
    pulse_trig();
    tick(150);
    chk("no_timeout_state", 32'(STATE), 32'd2);
    ENABLE = 1'b0;
    tick(1);
    chk("no_timeout_escape", 32'(STATE), 32'd0);
    ENABLE = 1'b1;
    tick(1);
    chk("no_timeout_buf_full", 32'(BUF_FULL), 32'b00);
`endif

    // Abort via ENABLE
    start_xfr(10);
    ENABLE = 1'b0;
    tick(1);
    chk("abort_state", 32'(STATE), 32'd0);
    chk("abort_rd_enable", 32'(RD_ENABLE), 32'd0);
    chk("abort_word_count", 32'(WORD_COUNT), 32'd10);
    chk("abort_buf_full", 32'(BUF_FULL), 32'b00);
    ENABLE_XFR = 1'b0;
    pulse_trig();
    chk("disabled_trig_ignored", 32'(LOST_TRIG), 32'd1);
    chk("disabled_trig_state", 32'(STATE), 32'd0);
    ENABLE = 1'b1;
    tick(2);

    // Reset mid-transfer
    do_xfr(32, 2'd0, 12'd32, 1'b0);
    start_xfr(5);
    chk("mid_wr_buf", 32'(WR_BUF), 32'd1);
    pulse_trig();
    chk("lost_trig_busy", 32'(LOST_TRIG), 32'd2);
    RESET = 1'b1; ENABLE_XFR = 1'b0;
    #2;
    chk("async_reset_outputs", {RD_ENABLE, RD_TRIGGER, WR_BUF, BUF_FULL, WORD_COUNT, XFR_DONE,
                                XFR_ERR, ERR_CODE, LOST_TRIG, STATE}, 32'd0);
    tick(1);
    RESET = 1'b0;
    tick(2);
    do_xfr(32, 2'd0, 12'd32, 1'b0);

    tick(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
